// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - register-file write-port arbiter between WB and a long-latency unit
module regfile_wr_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        wb_wen,
    input  logic [4:0]  wb_wsel,
    input  logic [31:0] wb_wdat,
    output logic        stall_wb,
    input  logic        ll_valid,
    input  logic [4:0]  ll_sel,
    input  logic [31:0] ll_dat,
    output logic        ll_ready,
    input  logic [4:0]  q_sel,
    output logic        pend_hit,
    output logic        WEN,
    output logic [4:0]  wsel,
    output logic [31:0] wdat
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t          state;
    state_t          state_next;

    logic [AW:0]     head;
    logic [AW:0]     tail;
    logic [DEPTH-1:0] live;
    logic [4:0]      sel_mem [DEPTH];
    logic [31:0]     dat_mem [DEPTH];
    logic [WW-1:0]   wait_cnt;

    logic [AW-1:0]   head_idx;
    logic [AW-1:0]   tail_idx;
    logic            empty;
    logic            full;
    logic            head_live;
    logic            wb_req;
    logic            wb_grant;
    logic            pop;
    logic            head_write;
    logic            push;
    logic            kill_new;
    logic            q_hit;

    assign head_idx  = head[AW-1:0];
    assign tail_idx  = tail[AW-1:0];
    assign empty     = (head == tail);
    assign full      = (head[AW] != tail[AW]) && (head_idx == tail_idx);
    assign head_live = !empty && live[head_idx];
    assign wb_req    = wb_wen && (wb_wsel != 5'd0);

    // Handshake side: ready tracks full only; r0 results complete the handshake but are dropped.
    assign ll_ready = nRST && !full;
    assign push     = ll_valid && ll_ready && (ll_sel != 5'd0);
    // An LL result to the register WB is writing right now is stale on arrival.
    assign kill_new = wb_grant && (ll_sel == wb_wsel);

    // State register for the NORMAL/DRAIN arbiter.
    always_ff @(posedge CLK) begin
        if (!nRST) state <= NORMAL;
        else       state <= state_next;
    end

    // Next state: one forced-drain cycle once the head has been starved long enough.
    always_comb begin
        state_next = state;
        case (state)
            NORMAL: if (!empty && !pop && (wait_cnt == WW'(MAX_WAIT - 1))) state_next = DRAIN;
            DRAIN:  state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    // FSM outputs: grant, pop decision and the register-file write mux.
    always_comb begin
        stall_wb   = (state == DRAIN);
        wb_grant   = nRST && (state == NORMAL) && wb_req;
        pop        = nRST && !empty && ((state == DRAIN) || !wb_req || !live[head_idx]);
        head_write = pop && head_live;
        WEN        = wb_grant || head_write;
        wsel       = 5'd0;
        wdat       = 32'd0;
        if (wb_grant) begin
            wsel = wb_wsel;
            wdat = wb_wdat;
        end else if (head_write) begin
            wsel = sel_mem[head_idx];
            wdat = dat_mem[head_idx];
        end
    end

    // Pointer, liveness and starvation-counter bookkeeping.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head     <= '0;
            tail     <= '0;
            live     <= '0;
            wait_cnt <= '0;
        end else begin
            if (push) tail <= tail + (AW+1)'(1);
            if (pop)  head <= head + (AW+1)'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (tail_idx == AW'(i)))
                    live[i] <= !kill_new;
                else if (pop && (head_idx == AW'(i)))
                    live[i] <= 1'b0;
                else if (wb_grant && (sel_mem[i] == wb_wsel))
                    live[i] <= 1'b0;
            end
            if (pop || empty) wait_cnt <= '0;
            else              wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Entry payload storage; contents are only meaningful while the live bit is set.
    always_ff @(posedge CLK) begin
        if (push) begin
            sel_mem[tail_idx] <= ll_sel;
            dat_mem[tail_idx] <= ll_dat;
        end
    end

    // Scoreboard query over live entries (pre-edge view).
    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (sel_mem[i] == q_sel)) q_hit = 1'b1;
        end
    end

    assign pend_hit = nRST && (q_sel != 5'd0) && q_hit;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - scoreboard bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        wb_wen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        stall_wb;
    logic        ll_valid;
    logic [4:0]  ll_sel;
    logic [31:0] ll_dat;
    logic        ll_ready;
    logic [4:0]  q_sel;
    logic        pend_hit;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;

    int n_vec = 0;
    int n_err = 0;

    logic [36:0] exp_q [$];
    logic [36:0] ll_src [$];
    logic [31:0] rf [32];
    logic        rdy_log [64];

    regfile_wr_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .stall_wb(stall_wb),
        .ll_valid(ll_valid), .ll_sel(ll_sel), .ll_dat(ll_dat), .ll_ready(ll_ready),
        .q_sel(q_sel), .pend_hit(pend_hit),
        .WEN(WEN), .wsel(wsel), .wdat(wdat)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] wbv(input int base, input int i);
        return {5'(base + i), 32'h0B00_0000 + 32'(i)};
    endfunction

    // Write-port monitor: every register-file write must be the next expected one.
    always @(negedge CLK) begin
        if (WEN !== 1'b0) begin
            rf[wsel] = wdat;
            if (exp_q.size() == 0) chk("wen_unexpected", {63'd0, WEN}, 64'd0);
            else                   chk("wr_order", {27'd0, wsel, wdat}, {27'd0, exp_q.pop_front()});
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        wb_wen   = 1'b0;
        ll_valid = 1'b0;
        repeat (n) cyc();
    endtask

    // Pipelined WB stream (held while stalled) plus LL stream with ready handshake.
    task automatic run(input int ncyc, input int wb_until, input int stall_cyc, input int base);
        int   wi;
        logic st;
        logic acc;
        wi = 0;
        for (int c = 0; c < ncyc; c++) begin
            wb_wen  = (c < wb_until);
            wb_wsel = 5'(base + wi);
            wb_wdat = 32'h0B00_0000 + 32'(wi);
            ll_valid = (ll_src.size() > 0);
            if (ll_valid) {ll_sel, ll_dat} = ll_src[0];
            @(negedge CLK);
            chk($sformatf("stall_wb_c%0d", c), {63'd0, stall_wb}, {63'd0, (c == stall_cyc)});
            rdy_log[c] = ll_ready;
            st  = stall_wb;
            acc = ll_valid && ll_ready;
            cyc();
            if (acc) void'(ll_src.pop_front());
            if (wb_wen && !st) wi++;
        end
        wb_wen   = 1'b0;
        ll_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        for (int i = 0; i < 64; i++) rdy_log[i] = 1'b0;
        nRST = 1'b0; wb_wen = 1'b1; wb_wsel = 5'd4; wb_wdat = 32'h44;
        ll_valid = 1'b1; ll_sel = 5'd6; ll_dat = 32'h66; q_sel = 5'd6;

        // Reset held with requests active
        repeat (3) begin
            @(negedge CLK);
            chk("rst_wen", {63'd0, WEN}, 64'd0);
            chk("rst_ready", {63'd0, ll_ready}, 64'd0);
            chk("rst_stall", {63'd0, stall_wb}, 64'd0);
            chk("rst_pend", {63'd0, pend_hit}, 64'd0);
            cyc();
        end
        nRST = 1'b1; wb_wen = 1'b0; ll_valid = 1'b0;
        @(negedge CLK);
        chk("rel_ready", {63'd0, ll_ready}, 64'd1);
        chk("rel_wen", {63'd0, WEN}, 64'd0);
        cyc();

        // LL only: one cycle latency, no bypass
        ll_valid = 1'b1; ll_sel = 5'd5; ll_dat = 32'hDEADBEEF; q_sel = 5'd5;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge CLK);
        chk("ll_c0_wen", {63'd0, WEN}, 64'd0);
        chk("ll_c0_ready", {63'd0, ll_ready}, 64'd1);
        cyc();
        ll_valid = 1'b0;
        @(negedge CLK);
        chk("ll_c1_wen", {63'd0, WEN}, 64'd1);
        chk("ll_c1_pend", {63'd0, pend_hit}, 64'd1);
        cyc();
        @(negedge CLK);
        chk("ll_c2_wen", {63'd0, WEN}, 64'd0);
        chk("ll_c2_pend", {63'd0, pend_hit}, 64'd0);
        cyc();
        chk("ll_q_empty", 64'(exp_q.size()), 64'd0);

        // Starvation: forced drain in cycle 9, held WB write follows
        ll_src.push_back({5'd3, 32'h0000_0333});
        for (int i = 0; i < 9; i++) exp_q.push_back(wbv(8, i));
        exp_q.push_back({5'd3, 32'h0000_0333});
        exp_q.push_back(wbv(8, 9));
        exp_q.push_back(wbv(8, 10));
        run(12, 12, 9, 8);
        idle(3);
        chk("starve_q_empty", 64'(exp_q.size()), 64'd0);

        // Full FIFO: 5th result waits for the first forced drain, order preserved
        for (int k = 0; k < 5; k++) ll_src.push_back({5'(10 + k), 32'hA0 + 32'(k)});
        for (int i = 0; i < 9; i++) exp_q.push_back(wbv(20, i));
        exp_q.push_back({5'd10, 32'hA0});
        exp_q.push_back(wbv(20, 9));
        for (int k = 1; k < 5; k++) exp_q.push_back({5'(10 + k), 32'hA0 + 32'(k)});
        run(16, 11, 9, 20);
        chk("full_rdy_c3", {63'd0, rdy_log[3]}, 64'd1);
        chk("full_rdy_c4", {63'd0, rdy_log[4]}, 64'd0);
        chk("full_rdy_c9", {63'd0, rdy_log[9]}, 64'd0);
        chk("full_rdy_c10", {63'd0, rdy_log[10]}, 64'd1);
        chk("full_src_empty", 64'(ll_src.size()), 64'd0);
        idle(3);
        chk("full_q_empty", 64'(exp_q.size()), 64'd0);

        // Kill: queued r7 and same-cycle r7 both dead after WB writes r7
        wb_wen = 1'b1; wb_wsel = 5'd9; wb_wdat = 32'h99;
        ll_valid = 1'b1; ll_sel = 5'd7; ll_dat = 32'h11; q_sel = 5'd7;
        exp_q.push_back({5'd9, 32'h99});
        @(negedge CLK);
        chk("kill_c0_pend", {63'd0, pend_hit}, 64'd0);
        cyc();
        wb_wsel = 5'd7; wb_wdat = 32'h22; ll_dat = 32'h33;
        exp_q.push_back({5'd7, 32'h22});
        @(negedge CLK);
        chk("kill_c1_pend", {63'd0, pend_hit}, 64'd1);
        cyc();
        wb_wen = 1'b0; ll_valid = 1'b0;
        @(negedge CLK);
        chk("kill_c2_pend", {63'd0, pend_hit}, 64'd0);
        chk("kill_c2_wen", {63'd0, WEN}, 64'd0);
        cyc();
        @(negedge CLK);
        chk("kill_c3_pend", {63'd0, pend_hit}, 64'd0);
        chk("kill_c3_wen", {63'd0, WEN}, 64'd0);
        cyc();
        idle(2);
        chk("kill_r7", 64'(rf[7]), 64'h22);
        chk("kill_q_empty", 64'(exp_q.size()), 64'd0);

        // r0 traffic never writes; accepted LL r0 still handshakes
        wb_wen = 1'b1; wb_wsel = 5'd0; wb_wdat = 32'h66;
        ll_valid = 1'b1; ll_sel = 5'd0; ll_dat = 32'h55; q_sel = 5'd0;
        repeat (2) begin
            @(negedge CLK);
            chk("r0_wen", {63'd0, WEN}, 64'd0);
            chk("r0_ready", {63'd0, ll_ready}, 64'd1);
            chk("r0_pend", {63'd0, pend_hit}, 64'd0);
            cyc();
        end

        // Three queued entries discarded by a mid-operation reset
        q_sel = 5'd2;
        for (int k = 0; k < 3; k++) begin
            wb_wen = 1'b1; wb_wsel = 5'(15 + k); wb_wdat = 32'h150 + 32'(k);
            ll_valid = 1'b1; ll_sel = (k == 2) ? 5'd4 : 5'(k + 1); ll_dat = 32'h70 + 32'(k);
            exp_q.push_back({5'(15 + k), 32'h150 + 32'(k)});
            @(negedge CLK);
            if (k == 2) chk("rst_mid_pend", {63'd0, pend_hit}, 64'd1);
            cyc();
        end
        wb_wen = 1'b0; ll_valid = 1'b0; nRST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_wen", {63'd0, WEN}, 64'd0);
        chk("rst_mid_pend0", {63'd0, pend_hit}, 64'd0);
        cyc();
        nRST = 1'b1; q_sel = 5'd1;
        @(negedge CLK);
        chk("rst_after_pend", {63'd0, pend_hit}, 64'd0);
        chk("rst_after_wen", {63'd0, WEN}, 64'd0);
        cyc();
        idle(12);
        chk("rst_q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
